adder_share_ctrl: RTL



---
 rtl/adder_share_if.sv | 32 +++
 rtl/adder_share_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/adder_share_if.sv
// Bundle of the three-requester request side and the single response side
// of the shared adder/subtractor.
interface adder_share_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_cout;
    logic                  rsp_ovf;
    logic [1:0]            fsm_state;

    // Handshake rule on both sides: a transfer happens in exactly the cycle
    // where valid and ready are both high; the valid side holds its payload
    // stable until then, and ready never depends on the payload.
    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf, fsm_state
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf, fsm_state
    );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter and IDLE/CALC/RESP sequencer sharing one 32-bit
// adder/subtractor between the PC incrementer, the AGU and the ALU.
module adder_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3
) (
    input  logic          clk,
    input  logic          reset,
    adder_share_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       last;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [1:0]       op_id;

    logic             rsp_valid_q;
    logic [1:0]       rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_cout_q;
    logic             rsp_ovf_q;

    logic [1:0]       c1;
    logic [1:0]       c2;
    logic [3:0]       valid_pad;
    logic [1:0]       winner;
    logic             win_ok;
    logic             grant_window;
    logic [2:0]       grant;
    logic             grant_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_sub;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;

    // Priority rotates from the requester after the last winner; the grant
    // window excludes reset so a request in the reset cycle is never accepted.
    always_comb begin
        c1        = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c2        = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        valid_pad = {1'b0, bus.req_valid};
        win_ok    = 1'b1;
        winner    = c1;
        if (valid_pad[c1]) begin
            winner = c1;
        end else if (valid_pad[c2]) begin
            winner = c2;
        end else if (valid_pad[last]) begin
            winner = last;
        end else begin
            win_ok = 1'b0;
        end

        grant_window = !reset && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
        grant = 3'b000;
        if (grant_window && win_ok) begin
            case (winner)
                2'd0:    grant = 3'b001;
                2'd1:    grant = 3'b010;
                default: grant = 3'b100;
            endcase
        end
        grant_any = |grant;

        case (winner)
            2'd0: begin
                sel_a   = bus.req_a[WIDTH-1:0];
                sel_b   = bus.req_b[WIDTH-1:0];
                sel_sub = bus.req_sub[0];
            end
            2'd1: begin
                sel_a   = bus.req_a[2*WIDTH-1:WIDTH];
                sel_b   = bus.req_b[2*WIDTH-1:WIDTH];
                sel_sub = bus.req_sub[1];
            end
            default: begin
                sel_a   = bus.req_a[3*WIDTH-1:2*WIDTH];
                sel_b   = bus.req_b[3*WIDTH-1:2*WIDTH];
                sel_sub = bus.req_sub[2];
            end
        endcase
    end

    // Subtraction is a + ~b + 1; overflow compares against the inverted operand.
    always_comb begin
        b_eff = op_sub ? ~op_b : op_b;
        sum   = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
        ovf   = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last         <= 2'd2;
            op_a         <= '0;
            op_b         <= '0;
            op_sub       <= 1'b0;
            op_id        <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 2'd0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_sub <= sel_sub;
                        op_id  <= winner;
                        last   <= winner;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_result_q <= sum[WIDTH-1:0];
                    rsp_cout_q   <= sum[WIDTH];
                    rsp_ovf_q    <= ovf;
                    rsp_id_q     <= op_id;
                    rsp_valid_q  <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (grant_any) begin
                            op_a   <= sel_a;
                            op_b   <= sel_b;
                            op_sub <= sel_sub;
                            op_id  <= winner;
                            last   <= winner;
                            state  <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.fsm_state  = state;
endmodule
